// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch port.
// Fetch side is master; memory is slave.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF stage: PC ownership, req/ack fetch,
// one-entry skid for stalls, IF/ID register.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   br_en,
  input  logic [31:0]            br_target,
  input  logic                   jmp_en,
  input  logic [31:0]            jmpadd,
  input  logic                   jr_en,
  input  logic [31:0]            jr_target,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            ins,
  output logic                   ins_valid
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] fetch_addr;
  logic [31:0] addr_q;
  logic        req_q;
  logic        discard;
  logic [31:0] skid_addr;
  logic [31:0] skid_data;

  logic        redir;
  logic        accept;
  logic [31:0] tgt;
  logic [31:0] seq;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // Redirect target (jr > br > jmp), word aligned
  always_comb begin
    redir  = jr_en | br_en | jmp_en;
    accept = req_q & imem.imem_ack;
    seq    = fetch_addr + 32'd4;
    tgt    = seq;
    if (jr_en)       tgt = jr_target & ~32'h3;
    else if (br_en)  tgt = br_target & ~32'h3;
    else if (jmp_en) tgt = jmpadd & ~32'h3;
  end

  // Fetch FSM with IF/ID and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      fetch_addr <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      discard    <= 1'b0;
      skid_addr  <= 32'h0;
      skid_data  <= 32'h0;
      pc         <= 32'h0;
      pc_plus4   <= 32'd4;
      ins        <= 32'h0;
      ins_valid  <= 1'b0;
    end else begin
      if (flush) begin
        ins_valid <= 1'b0;
        ins       <= 32'h0;
      end else if (!stall) begin
        ins_valid <= 1'b0;
      end
      unique case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
          if (redir) begin
            fetch_addr <= tgt;
            addr_q     <= tgt;
          end
        end
        FETCH: begin
          if (discard) begin
            if (accept) begin
              discard <= 1'b0;
              addr_q  <= redir ? tgt : fetch_addr;
            end
            if (redir) fetch_addr <= tgt;
          end else if (redir) begin
            fetch_addr <= tgt;
            if (accept) addr_q  <= tgt;
            else        discard <= 1'b1;
          end else if (accept && flush) begin
            // word dropped; same address is refetched
            fetch_addr <= fetch_addr;
          end else if (accept && stall) begin
            skid_addr  <= addr_q;
            skid_data  <= imem.imem_rdata;
            state      <= HOLD;
            req_q      <= 1'b0;
            fetch_addr <= seq;
            addr_q     <= seq;
          end else if (accept) begin
            pc         <= addr_q;
            pc_plus4   <= addr_q + 32'd4;
            ins        <= imem.imem_rdata;
            ins_valid  <= 1'b1;
            fetch_addr <= seq;
            addr_q     <= seq;
          end
        end
        HOLD: begin
          if (redir) begin
            fetch_addr <= tgt;
            addr_q     <= tgt;
            state      <= FETCH;
            req_q      <= 1'b1;
          end else if (!flush && !stall) begin
            pc        <= skid_addr;
            pc_plus4  <= skid_addr + 32'd4;
            ins       <= skid_data;
            ins_valid <= 1'b1;
            state     <= FETCH;
            req_q     <= 1'b1;
          end
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
// Memory returns addr ^ C0DE_0000.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jmp_en = 1'b0;
  logic [31:0] jmpadd = 32'h0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        ack = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ins;
  logic        ins_valid;

  int n_chk = 0;
  int n_pass = 0;
  int bad_seen = 0;

  fetch_pc_unit_if mif ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign mif.imem_ack   = ack;
  assign mif.imem_rdata = mem(mif.imem_addr);

  fetch_pc_unit #(.RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .br_en     (br_en),
    .br_target (br_target),
    .jmp_en    (jmp_en),
    .jmpadd    (jmpadd),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .imem      (mif),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .ins       (ins),
    .ins_valid (ins_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && ins_valid &&
        (pc == 32'h10 || pc == 32'h14))
      bad_seen++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    chk("rst_req", 32'(mif.imem_req), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_ins", ins, 32'h0);
    chk("rst_vld", 32'(ins_valid), 32'h0);
    rst_n = 1'b1;

    // sequential fetch
    tick();
    chk("boot_req", 32'(mif.imem_req), 32'h1);
    chk("boot_addr", mif.imem_addr, 32'h0);
    chk("boot_vld", 32'(ins_valid), 32'h0);
    tick();
    chk("seq_vld", 32'(ins_valid), 32'h1);
    chk("seq_pc0", pc, 32'h0);
    chk("seq_ins0", ins, mem(32'h0));
    chk("seq_addr4", mif.imem_addr, 32'h4);
    tick();
    chk("seq_addr8", mif.imem_addr, 32'h8);
    chk("seq_pc4", pc, 32'h4);
    tick();
    chk("seq_addrC", mif.imem_addr, 32'hC);
    tick();
    chk("seq_addr10", mif.imem_addr, 32'h10);
    chk("seq_pcC", pc, 32'hC);

    // jump while fetching 0x10
    jmp_en = 1'b1;
    jmpadd = 32'h0040_0100;
    tick();
    jmp_en = 1'b0;
    chk("jmp_addr", mif.imem_addr, 32'h0040_0100);
    chk("jmp_vld", 32'(ins_valid), 32'h0);
    tick();
    chk("jmp_pc", pc, 32'h0040_0100);
    chk("jmp_ins", ins, mem(32'h0040_0100));

    // delayed ack with jr during the wait
    ack = 1'b0;
    tick();
    jr_en = 1'b1;
    jr_target = 32'h200;
    tick();
    jr_en = 1'b0;
    chk("wait_addr", mif.imem_addr, 32'h0040_0104);
    chk("wait_req", 32'(mif.imem_req), 32'h1);
    tick();
    chk("wait_addr2", mif.imem_addr, 32'h0040_0104);
    ack = 1'b1;
    tick();
    chk("drop_addr", mif.imem_addr, 32'h200);
    chk("drop_vld", 32'(ins_valid), 32'h0);
    tick();
    chk("jr_pc", pc, 32'h200);
    chk("jr_ins", ins, mem(32'h200));

    // stall across an accept
    stall = 1'b1;
    tick();
    chk("hold_req", 32'(mif.imem_req), 32'h0);
    chk("hold_pc", pc, 32'h200);
    tick();
    tick();
    tick();
    chk("hold_req4", 32'(mif.imem_req), 32'h0);
    chk("hold_pc4", pc, 32'h200);
    chk("hold_vld", 32'(ins_valid), 32'h1);
    stall = 1'b0;
    tick();
    chk("skid_pc", pc, 32'h204);
    chk("skid_ins", ins, mem(32'h204));
    chk("skid_addr", mif.imem_addr, 32'h208);
    tick();
    chk("after_pc", pc, 32'h208);

    // flush beats stall and accept
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("fl_vld", 32'(ins_valid), 32'h0);
    chk("fl_ins", ins, 32'h0);
    chk("fl_pc", pc, 32'h208);
    tick();
    chk("refetch_pc", pc, 32'h20C);

    // br beats jmp, target aligned
    br_en = 1'b1;
    br_target = 32'h3002;
    jmp_en = 1'b1;
    jmpadd = 32'h5000;
    tick();
    br_en = 1'b0;
    chk("br_win", mif.imem_addr, 32'h3000);

    // wrap at top of address space
    jmpadd = 32'hFFFF_FFFC;
    tick();
    jmp_en = 1'b0;
    chk("top_addr", mif.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc4", pc_plus4, 32'h0);
    chk("wrap_addr", mif.imem_addr, 32'h0);

    // jr beats br
    jr_en = 1'b1;
    jr_target = 32'h701;
    br_en = 1'b1;
    br_target = 32'h800;
    tick();
    jr_en = 1'b0;
    br_en = 1'b0;
    chk("jr_win", mif.imem_addr, 32'h700);
    tick();
    chk("jr_win_pc", pc, 32'h700);
    chk("no_0x10_0x14", bad_seen, 0);

    // async reset drops request
    chk("pre_rst_req", 32'(mif.imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(mif.imem_req), 32'h0);
    chk("async_vld", 32'(ins_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
